// File: rtl/sram_controller_if.sv
// MEM-stage request/response bundle between the pipeline and sram_controller.
interface sram_controller_if;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;

    modport master (
        output wr_en, rd_en, address, write_data,
        input  read_data, ready
    );

    modport slave (
        input  wr_en, rd_en, address, write_data,
        output read_data, ready
    );
endinterface

// File: rtl/sram_controller.sv
// Splits 32-bit MEM-stage loads/stores into low-then-high halfword accesses on a 16-bit async SRAM.
// Optional macro SRAM_ADDR_OFFSET_EN rebases byte addresses by -1024 (data memory base).
module sram_controller #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    sram_controller_if.slave   bus,
    inout  wire  [15:0]        sram_dq,
    output logic [17:0]        sram_addr,
    output logic               sram_we_n,
    output logic               sram_ub_n,
    output logic               sram_lb_n,
    output logic               sram_ce_n,
    output logic               sram_oe_n
);
    localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_wr_q, is_wr_d;
    logic [16:0]        word_q, word_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        read_data_q, read_data_d;
    logic [17:0]        sram_addr_q, sram_addr_d;
    logic               we_n_q, we_n_d;
    logic               dq_oe_q, dq_oe_d;
    logic [15:0]        dq_out_q, dq_out_d;
    logic               req_s;
    logic               last_s;
    logic               ready_s;
    logic [18:0]        ea_s;
    logic               unused_addr_s;

`ifdef SRAM_ADDR_OFFSET_EN
    // The borrow of -1024 only propagates upward, so bits above 18 never reach the word index.
    assign ea_s = bus.address[18:0] - 19'd1024;
`else
    assign ea_s = bus.address[18:0];
`endif
    assign unused_addr_s = ^{bus.address[31:19], ea_s[1:0]};

    assign req_s  = bus.rd_en | bus.wr_en;
    assign last_s = (cnt_q == CNT_LAST);

    // Next-state, phase counter and read capture; outputs are precomputed from the next state.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        is_wr_d     = is_wr_q;
        word_d      = word_q;
        wdata_d     = wdata_q;
        read_data_d = read_data_q;
        ready_s     = 1'b0;
        sram_addr_d = 18'd0;
        we_n_d      = 1'b1;
        dq_oe_d     = 1'b0;
        dq_out_d    = 16'd0;

        case (state_q)
            IDLE: begin
                ready_s = ~req_s;
                if (req_s) begin
                    state_d = LOW;
                    cnt_d   = '0;
                    is_wr_d = bus.wr_en;
                    word_d  = ea_s[18:2];
                    wdata_d = bus.write_data;
                end else begin
                    cnt_d   = '0;
                end
            end
            LOW: begin
                if (last_s) begin
                    if (!is_wr_q) begin
                        read_data_d[15:0] = sram_dq;
                    end else begin
                        read_data_d = read_data_q;
                    end
                    state_d = HIGH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HIGH: begin
                if (last_s) begin
                    if (!is_wr_q) begin
                        read_data_d[31:16] = sram_dq;
                    end else begin
                        read_data_d = read_data_q;
                    end
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            DONE: begin
                ready_s = 1'b1;
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        case (state_d)
            LOW: begin
                sram_addr_d = {word_d, 1'b0};
                we_n_d      = ~is_wr_d;
                dq_oe_d     = is_wr_d;
                dq_out_d    = wdata_d[15:0];
            end
            HIGH: begin
                sram_addr_d = {word_d, 1'b1};
                we_n_d      = ~is_wr_d;
                dq_oe_d     = is_wr_d;
                dq_out_d    = wdata_d[31:16];
            end
            default: begin
                sram_addr_d = 18'd0;
                we_n_d      = 1'b1;
                dq_oe_d     = 1'b0;
                dq_out_d    = 16'd0;
            end
        endcase
    end

    // State and registered SRAM pin drivers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            is_wr_q     <= 1'b0;
            word_q      <= 17'd0;
            wdata_q     <= 32'd0;
            read_data_q <= 32'd0;
            sram_addr_q <= 18'd0;
            we_n_q      <= 1'b1;
            dq_oe_q     <= 1'b0;
            dq_out_q    <= 16'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_wr_q     <= is_wr_d;
            word_q      <= word_d;
            wdata_q     <= wdata_d;
            read_data_q <= read_data_d;
            sram_addr_q <= sram_addr_d;
            we_n_q      <= we_n_d;
            dq_oe_q     <= dq_oe_d;
            dq_out_q    <= dq_out_d;
        end
    end

    assign sram_dq       = dq_oe_q ? dq_out_q : 16'hzzzz;
    assign sram_addr     = sram_addr_q;
    assign sram_we_n     = we_n_q;
    assign sram_ub_n     = 1'b0;
    assign sram_lb_n     = 1'b0;
    assign sram_ce_n     = 1'b0;
    assign sram_oe_n     = 1'b0;
    assign bus.read_data = read_data_q;
    assign bus.ready     = ready_s;
endmodule

// File: tb/tb_sram_controller.sv
// Scoreboard bench: drivers queue expected responses, negedge monitors check SRAM pins, latency and data.
module tb_sram_controller;
    localparam int WA = 2;
    localparam int WB = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] rdata;
        logic [17:0] lo;
        logic        wr;
    } exp_t;

    exp_t exp_a[$];
    exp_t exp_b[$];
    int   cyc_a = 0;
    int   cyc_b = 0;

    // Instance A: WAIT_CYCLES = 2 with a RAM model
    sram_controller_if bus_a();
    wire  [15:0] dq_a;
    logic [17:0] addr_a;
    logic        we_n_a, ub_a, lb_a, ce_a, oe_a;
    logic [15:0] mem_a [0:262143];

    sram_controller #(.WAIT_CYCLES(WA)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a), .sram_dq(dq_a), .sram_addr(addr_a),
        .sram_we_n(we_n_a), .sram_ub_n(ub_a), .sram_lb_n(lb_a), .sram_ce_n(ce_a), .sram_oe_n(oe_a)
    );

    assign dq_a = we_n_a ? mem_a[addr_a] : 16'hzzzz;
    always @(posedge clk) if (!we_n_a) mem_a[addr_a] <= dq_a;

    // Instance B: WAIT_CYCLES = 1 with a ROM returning 0xC000 ^ halfword address
    sram_controller_if bus_b();
    wire  [15:0] dq_b;
    logic [17:0] addr_b;
    logic        we_n_b, ub_b, lb_b, ce_b, oe_b;

    sram_controller #(.WAIT_CYCLES(WB)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b), .sram_dq(dq_b), .sram_addr(addr_b),
        .sram_we_n(we_n_b), .sram_ub_n(ub_b), .sram_lb_n(lb_b), .sram_ce_n(ce_b), .sram_oe_n(oe_b)
    );

    assign dq_b = we_n_b ? (16'hC000 ^ addr_b[15:0]) : 16'hzzzz;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic logic [17:0] lo_of(input logic [31:0] a);
        logic [31:0] ea;
`ifdef SRAM_ADDR_OFFSET_EN
        ea = a - 32'd1024;
`else
        ea = a;
`endif
        return {ea[18:2], 1'b0};
    endfunction

    // Monitor A: per-cycle pin checks, completion latency and read data against the queue head
    always @(negedge clk) begin
        if (rst) begin
            cyc_a = 0;
        end else if ((bus_a.rd_en | bus_a.wr_en) && exp_a.size() != 0) begin
            if (bus_a.ready) begin
                chk("a_latency", 32'(cyc_a), 32'(2 * WA + 1));
                chk("a_read_data", bus_a.read_data, exp_a[0].rdata);
                chk("a_done_addr", {14'd0, addr_a}, 32'd0);
                void'(exp_a.pop_front());
                cyc_a = 0;
            end else begin
                if (cyc_a == 0) begin
                    chk("a_idle_addr", {14'd0, addr_a}, 32'd0);
                end else if (cyc_a <= WA) begin
                    chk("a_low_addr", {14'd0, addr_a}, {14'd0, exp_a[0].lo});
                    chk("a_low_we_n", {31'd0, we_n_a}, {31'd0, ~exp_a[0].wr});
                end else if (cyc_a <= 2 * WA) begin
                    chk("a_high_addr", {14'd0, addr_a}, {14'd0, exp_a[0].lo | 18'd1});
                    chk("a_high_we_n", {31'd0, we_n_a}, {31'd0, ~exp_a[0].wr});
                end
                cyc_a++;
                if (cyc_a > 40) begin
                    chk("a_timeout", 32'd1, 32'd0);
                    void'(exp_a.pop_front());
                    cyc_a = 0;
                end
            end
        end
    end

    // Monitor B: ready timing and data for the single-cycle-wait instance
    always @(negedge clk) begin
        if (rst) begin
            cyc_b = 0;
        end else if ((bus_b.rd_en | bus_b.wr_en) && exp_b.size() != 0) begin
            if (bus_b.ready) begin
                chk("b_latency", 32'(cyc_b), 32'(2 * WB + 1));
                chk("b_read_data", bus_b.read_data, exp_b[0].rdata);
                void'(exp_b.pop_front());
                cyc_b = 0;
            end else begin
                cyc_b++;
                if (cyc_b > 40) begin
                    chk("b_timeout", 32'd1, 32'd0);
                    void'(exp_b.pop_front());
                    cyc_b = 0;
                end
            end
        end
    end

    task automatic xfer_a(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] exp_rd, input bit keep);
        exp_t e;
        e.rdata = exp_rd;
        e.lo    = lo_of(a);
        e.wr    = wr;
        exp_a.push_back(e);
        bus_a.rd_en      = rd;
        bus_a.wr_en      = wr;
        bus_a.address    = a;
        bus_a.write_data = d;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus_a.ready) break;
            if (i == 49) chk("a_wait_ready", 32'd0, 32'd1);
        end
        @(posedge clk);
        #1;
        if (!keep) begin
            bus_a.rd_en = 1'b0;
            bus_a.wr_en = 1'b0;
        end
    endtask

    initial begin
        bus_a.rd_en = 1'b0; bus_a.wr_en = 1'b1;
        bus_a.address = 32'd0; bus_a.write_data = 32'd0;
        bus_b.rd_en = 1'b0; bus_b.wr_en = 1'b0;
        bus_b.address = 32'd0; bus_b.write_data = 32'd0;

        // Reset held for three cycles with a store request present
        repeat (3) begin
            @(negedge clk);
            chk("rst_we_n", {31'd0, we_n_a}, 32'd1);
            chk("rst_read_data", bus_a.read_data, 32'd0);
            chk("rst_addr", {14'd0, addr_a}, 32'd0);
            chk("rst_ready", {31'd0, bus_a.ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus_a.wr_en = 1'b0;
        @(negedge clk);
        chk("idle_ready", {31'd0, bus_a.ready}, 32'd1);
        chk("idle_we_n", {31'd0, we_n_a}, 32'd1);
        @(posedge clk);
        #1;

        xfer_a(1'b0, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 1'b0);
        chk("mem_beef", {16'd0, mem_a[lo_of(32'h100)]}, 32'h0000_BEEF);
        chk("mem_dead", {16'd0, mem_a[lo_of(32'h100) | 18'd1]}, 32'h0000_DEAD);
        xfer_a(1'b1, 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 1'b0);

        // Both requests high: treated as a store, read_data untouched
        xfer_a(1'b1, 1'b1, 32'h0000_0000, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0);
        chk("mem_5678", {16'd0, mem_a[lo_of(32'h0)]}, 32'h0000_5678);
        chk("mem_1234", {16'd0, mem_a[lo_of(32'h0) | 18'd1]}, 32'h0000_1234);

        xfer_a(1'b0, 1'b1, 32'h0000_0408, 32'h0BAD_F00D, 32'hDEAD_BEEF, 1'b0);
        xfer_a(1'b0, 1'b1, 32'h0000_03FC, 32'hA5A5_5A5A, 32'hDEAD_BEEF, 1'b0);
        xfer_a(1'b1, 1'b0, 32'h0000_03FF, 32'h0, 32'hA5A5_5A5A, 1'b1);
        xfer_a(1'b1, 1'b0, 32'h0000_0000, 32'h0, 32'h1234_5678, 1'b0);
        xfer_a(1'b1, 1'b0, 32'h0000_0408, 32'h0, 32'h0BAD_F00D, 1'b0);

        // Reset asserted during cycle 3 of a load abandons it
        bus_a.rd_en = 1'b1;
        bus_a.address = 32'h0000_0100;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus_a.rd_en = 1'b0;
        @(negedge clk);
        chk("abort_read_data", bus_a.read_data, 32'd0);
        chk("abort_ready", {31'd0, bus_a.ready}, 32'd1);
        chk("abort_addr", {14'd0, addr_a}, 32'd0);
        chk("abort_we_n", {31'd0, we_n_a}, 32'd1);
        @(posedge clk);
        #1;
        xfer_a(1'b1, 1'b0, 32'h0000_0000, 32'h0, 32'h1234_5678, 1'b0);

        // W=1 back-to-back loads: ready in cycles 3 and 7
        exp_b.push_back('{rdata: 32'hC001_C000, lo: 18'd0, wr: 1'b0});
        exp_b.push_back('{rdata: 32'hC003_C002, lo: 18'd2, wr: 1'b0});
        bus_b.rd_en = 1'b1;
        bus_b.address = 32'h0000_0000;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 50; i++) begin
                @(negedge clk);
                if (bus_b.ready) break;
                if (i == 49) chk("b_wait_ready", 32'd0, 32'd1);
            end
            @(posedge clk);
            #1;
            bus_b.address = 32'h0000_0004;
        end
        bus_b.rd_en = 1'b0;
        repeat (2) @(posedge clk);

        chk("queue_a_empty", 32'(exp_a.size()), 32'd0);
        chk("queue_b_empty", 32'(exp_b.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end
endmodule
